// File: rtl/pipelined_control_unit.sv
// Main control for the RV32I 5-stage pipeline: ID decode, ID/EX with stall/flush,
// EX/MEM and MEM/WB control registers, EX-stage redirect and illegal-opcode status.
module pipelined_control_unit #(
  parameter int IMM_W          = 3,
  parameter int ENABLE_JUMP    = 1,
  parameter int FLUSH_ON_TAKEN = 1,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             valid_d,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic             zero_e,
  output logic [IMM_W-1:0] imm_src_d,
  output logic             reg_write_e,
  output logic             alu_src_e,
  output logic             mem_write_e,
  output logic             branch_e,
  output logic             jump_e,
  output logic [1:0]       result_src_e,
  output logic [1:0]       alu_op_e,
  output logic             valid_e,
  output logic             pc_src_e,
  output logic             reg_write_m,
  output logic             mem_write_m,
  output logic [1:0]       result_src_m,
  output logic             reg_write_w,
  output logic [1:0]       result_src_w,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [IMM_W-1:0] IMM_I = IMM_W'(3'b000);
  localparam logic [IMM_W-1:0] IMM_S = IMM_W'(3'b001);
  localparam logic [IMM_W-1:0] IMM_B = IMM_W'(3'b010);
  localparam logic [IMM_W-1:0] IMM_J = IMM_W'(3'b011);
  localparam logic [IMM_W-1:0] IMM_U = IMM_W'(3'b100);

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ex_t;

  typedef struct packed {
    logic             legal;
    logic [IMM_W-1:0] imm;
    ex_t              ex;
  } dec_t;

  function automatic ex_t mk(input logic rw, input logic asrc, input logic mw,
                             input logic [1:0] res, input logic br, input logic j,
                             input logic [1:0] aop);
    ex_t e;
    e.reg_write  = rw;
    e.alu_src    = asrc;
    e.mem_write  = mw;
    e.result_src = res;
    e.branch     = br;
    e.jump       = j;
    e.alu_op     = aop;
    return e;
  endfunction

  function automatic dec_t decode(input logic [6:0] opcode, input logic vld);
    dec_t d;
    d = '0;
    if (vld) begin
      case (opcode)
        OP_LOAD:  begin d.legal = 1'b1; d.imm = IMM_I;
                        d.ex = mk(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00); end
        OP_STORE: begin d.legal = 1'b1; d.imm = IMM_S;
                        d.ex = mk(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00); end
        OP_R:     begin d.legal = 1'b1; d.imm = IMM_I;
                        d.ex = mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10); end
        OP_IALU:  begin d.legal = 1'b1; d.imm = IMM_I;
                        d.ex = mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10); end
        OP_BR:    begin d.legal = 1'b1; d.imm = IMM_B;
                        d.ex = mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01); end
        OP_JAL:   if (ENABLE_JUMP != 0) begin
                        d.legal = 1'b1; d.imm = IMM_J;
                        d.ex = mk(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 2'b00); end
        OP_JALR:  if (ENABLE_JUMP != 0) begin
                        d.legal = 1'b1; d.imm = IMM_I;
                        d.ex = mk(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 2'b00); end
        OP_LUI:   if (ENABLE_JUMP != 0) begin
                        d.legal = 1'b1; d.imm = IMM_U;
                        d.ex = mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11); end
        default:  d = '0;
      endcase
    end
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

  // ---- ID stage (p0): combinational decode ----
  dec_t dec_p0;
  logic bubble_e, load_e;

  assign dec_p0    = decode(op, valid_d);
  assign imm_src_d = dec_p0.imm;

  // ---- ID/EX (p1) ----
  ex_t  ctl_p1;
  logic vld_p1;
  logic fresh_p1;  // EX contents not yet passed on; a held instruction moves to MEM only once

  assign pc_src_e = vld_p1 & (ctl_p1.jump | (ctl_p1.branch & zero_e));
  assign bubble_e = flush_e | ((FLUSH_ON_TAKEN != 0) & pc_src_e);
  assign load_e   = ~bubble_e & ~stall_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_p1   <= '0;
      vld_p1   <= 1'b0;
      fresh_p1 <= 1'b0;
    end else if (bubble_e) begin
      ctl_p1   <= '0;
      vld_p1   <= 1'b0;
      fresh_p1 <= 1'b0;
    end else if (stall_e) begin
      fresh_p1 <= 1'b0;
    end else begin
      ctl_p1   <= dec_p0.ex;
      vld_p1   <= valid_d;
      fresh_p1 <= 1'b1;
    end
  end

  assign reg_write_e  = ctl_p1.reg_write;
  assign alu_src_e    = ctl_p1.alu_src;
  assign mem_write_e  = ctl_p1.mem_write;
  assign branch_e     = ctl_p1.branch;
  assign jump_e       = ctl_p1.jump;
  assign result_src_e = ctl_p1.result_src;
  assign alu_op_e     = ctl_p1.alu_op;
  assign valid_e      = vld_p1;

  // ---- EX/MEM (p2) and MEM/WB (p3) ----
  logic       reg_write_p2, mem_write_p2, reg_write_p3;
  logic [1:0] result_src_p2, result_src_p3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_p2  <= 1'b0;
      mem_write_p2  <= 1'b0;
      result_src_p2 <= 2'b00;
      reg_write_p3  <= 1'b0;
      result_src_p3 <= 2'b00;
    end else begin
      reg_write_p2  <= fresh_p1 & ctl_p1.reg_write;
      mem_write_p2  <= fresh_p1 & ctl_p1.mem_write;
      result_src_p2 <= fresh_p1 ? ctl_p1.result_src : 2'b00;
      reg_write_p3  <= reg_write_p2;
      result_src_p3 <= result_src_p2;
    end
  end

  assign reg_write_m  = reg_write_p2;
  assign mem_write_m  = mem_write_p2;
  assign result_src_m = result_src_p2;
  assign reg_write_w  = reg_write_p3;
  assign result_src_w = result_src_p3;

  // Illegal status counts only instructions that actually enter EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_o   <= 1'b0;
      illegal_cnt <= '0;
    end else if (load_e && valid_d && !dec_p0.legal) begin
      illegal_o   <= 1'b1;
      illegal_cnt <= sat_inc(illegal_cnt);
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: default instance plus an ENABLE_JUMP=0 instance.
module tb_pipelined_control_unit;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] RTYP  = 7'b0110011;
  localparam logic [6:0] IALU  = 7'b0010011;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] BAD   = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n, valid_d, stall_e, flush_e, zero_e;
  logic [6:0] op;

  logic [2:0] imm_src_d;
  logic reg_write_e, alu_src_e, mem_write_e, branch_e, jump_e, valid_e, pc_src_e;
  logic [1:0] result_src_e, alu_op_e, result_src_m, result_src_w;
  logic reg_write_m, mem_write_m, reg_write_w, illegal_o;
  logic [7:0] illegal_cnt;

  logic [2:0] nj_imm_src_d;
  logic nj_reg_write_e, nj_alu_src_e, nj_mem_write_e, nj_branch_e, nj_jump_e, nj_valid_e, nj_pc_src_e;
  logic [1:0] nj_result_src_e, nj_alu_op_e, nj_result_src_m, nj_result_src_w;
  logic nj_reg_write_m, nj_mem_write_m, nj_reg_write_w, nj_illegal_o;
  logic [7:0] nj_illegal_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipelined_control_unit dut (
    .clk(clk), .rst_n(rst_n), .op(op), .valid_d(valid_d), .stall_e(stall_e),
    .flush_e(flush_e), .zero_e(zero_e), .imm_src_d(imm_src_d),
    .reg_write_e(reg_write_e), .alu_src_e(alu_src_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e), .jump_e(jump_e), .result_src_e(result_src_e),
    .alu_op_e(alu_op_e), .valid_e(valid_e), .pc_src_e(pc_src_e),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
    .reg_write_w(reg_write_w), .result_src_w(result_src_w),
    .illegal_o(illegal_o), .illegal_cnt(illegal_cnt)
  );

  pipelined_control_unit #(.ENABLE_JUMP(0)) dut_nj (
    .clk(clk), .rst_n(rst_n), .op(op), .valid_d(valid_d), .stall_e(stall_e),
    .flush_e(flush_e), .zero_e(zero_e), .imm_src_d(nj_imm_src_d),
    .reg_write_e(nj_reg_write_e), .alu_src_e(nj_alu_src_e), .mem_write_e(nj_mem_write_e),
    .branch_e(nj_branch_e), .jump_e(nj_jump_e), .result_src_e(nj_result_src_e),
    .alu_op_e(nj_alu_op_e), .valid_e(nj_valid_e), .pc_src_e(nj_pc_src_e),
    .reg_write_m(nj_reg_write_m), .mem_write_m(nj_mem_write_m), .result_src_m(nj_result_src_m),
    .reg_write_w(nj_reg_write_w), .result_src_w(nj_result_src_w),
    .illegal_o(nj_illegal_o), .illegal_cnt(nj_illegal_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] o, input logic v);
    op = o;
    valid_d = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; op = '0; valid_d = 1'b0; stall_e = 1'b0; flush_e = 1'b0; zero_e = 1'b0;
    #12;
    check("rst_valid_e", valid_e, 0);
    check("rst_illegal_o", illegal_o, 0);
    check("rst_cnt", illegal_cnt, 0);
    check("rst_pc_src", pc_src_e, 0);
    check("rst_imm_novalid", imm_src_d, 0);
    rst_n = 1'b1;

    // load, R, branch back to back
    issue(LOAD, 1'b1); #1;
    check("imm_load", imm_src_d, 3'b000);
    tick();
    check("ld_valid_e", valid_e, 1);
    check("ld_rw_e", reg_write_e, 1);
    check("ld_asrc_e", alu_src_e, 1);
    check("ld_res_e", result_src_e, 2'b01);
    check("ld_pcsrc", pc_src_e, 0);
    issue(RTYP, 1'b1);
    tick();
    check("r_valid_e", valid_e, 1);
    check("r_aluop_e", alu_op_e, 2'b10);
    check("r_asrc_e", alu_src_e, 0);
    check("ld_res_m", result_src_m, 2'b01);
    issue(BR, 1'b1); zero_e = 1'b0; #1;
    check("imm_br", imm_src_d, 3'b010);
    tick();
    check("b_valid_e", valid_e, 1);
    check("b_branch_e", branch_e, 1);
    check("b_aluop_e", alu_op_e, 2'b01);
    check("b_pcsrc_z0", pc_src_e, 0);
    zero_e = 1'b1; #1;
    check("b_pcsrc_z1", pc_src_e, 1);
    check("ld_res_w", result_src_w, 2'b01);
    check("ld_rw_w", reg_write_w, 1);
    issue(RTYP, 1'b1);
    tick();
    check("taken_flush_valid", valid_e, 0);
    check("taken_flush_rw", reg_write_e, 0);
    check("r_res_w", result_src_w, 2'b00);
    check("r_rw_w", reg_write_w, 1);
    zero_e = 1'b0; issue(7'd0, 1'b0);
    tick();
    check("b_rw_w", reg_write_w, 0);
    check("nop_valid_e", valid_e, 0);

    // JAL redirect and flush; ENABLE_JUMP=0 instance treats it as illegal
    issue(JAL, 1'b1); #1;
    check("imm_jal", imm_src_d, 3'b011);
    tick();
    check("jal_pcsrc", pc_src_e, 1);
    check("jal_jump_e", jump_e, 1);
    check("jal_rw_e", reg_write_e, 1);
    check("jal_res_e", result_src_e, 2'b10);
    check("nj_jal_jump_e", nj_jump_e, 0);
    check("nj_jal_rw_e", nj_reg_write_e, 0);
    check("nj_cnt1", nj_illegal_cnt, 1);
    check("jal_cnt_main", illegal_cnt, 0);
    tick();
    check("jal_flush_valid", valid_e, 0);
    check("jal_flush_jump", jump_e, 0);
    check("jal_flush_rw", reg_write_e, 0);
    check("jal_flush_res", result_src_e, 0);
    check("jal_flush_pcsrc", pc_src_e, 0);
    check("jal_res_m", result_src_m, 2'b10);
    check("nj_cnt2", nj_illegal_cnt, 2);
    issue(7'd0, 1'b0);
    tick();

    // JALR, LUI, I-ALU decode
    issue(JALR, 1'b1);
    tick();
    check("jalr_pcsrc", pc_src_e, 1);
    check("jalr_asrc", alu_src_e, 1);
    check("jalr_res", result_src_e, 2'b10);
    issue(LUI, 1'b0);
    tick();
    issue(LUI, 1'b1); #1;
    check("imm_lui", imm_src_d, 3'b100);
    tick();
    check("lui_aluop", alu_op_e, 2'b11);
    check("lui_asrc", alu_src_e, 1);
    check("lui_rw", reg_write_e, 1);
    issue(IALU, 1'b1);
    tick();
    check("ialu_aluop", alu_op_e, 2'b10);
    check("ialu_asrc", alu_src_e, 1);

    // store held by a 3-cycle stall; illegal ops arriving meanwhile are not counted
    issue(STORE, 1'b1); #1;
    check("imm_store", imm_src_d, 3'b001);
    tick();
    check("st_mw_e", mem_write_e, 1);
    stall_e = 1'b1; issue(BAD, 1'b1);
    tick();
    check("stall1_mw_e", mem_write_e, 1);
    check("stall1_mw_m", mem_write_m, 1);
    tick();
    check("stall2_mw_e", mem_write_e, 1);
    check("stall2_mw_m", mem_write_m, 0);
    tick();
    check("stall3_mw_e", mem_write_e, 1);
    check("stall3_mw_m", mem_write_m, 0);
    check("stall3_valid", valid_e, 1);
    flush_e = 1'b1;
    tick();
    check("stflush_valid", valid_e, 0);
    check("stflush_mw_e", mem_write_e, 0);
    check("stall_cnt", illegal_cnt, 0);
    check("stall_illegal", illegal_o, 0);
    stall_e = 1'b0; flush_e = 1'b0;

    // illegal opcode counting and saturation
    tick();
    check("ill_first_o", illegal_o, 1);
    check("ill_first_cnt", illegal_cnt, 1);
    valid_d = 1'b0;
    tick();
    check("ill_novalid_cnt", illegal_cnt, 1);
    valid_d = 1'b1; flush_e = 1'b1;
    tick();
    check("ill_flush_cnt", illegal_cnt, 1);
    flush_e = 1'b0;
    for (int i = 0; i < 254; i++) tick();
    check("ill_cnt_255", illegal_cnt, 255);
    for (int i = 0; i < 45; i++) tick();
    check("ill_cnt_sat", illegal_cnt, 255);
    check("ill_o_sticky", illegal_o, 1);

    // asynchronous reset with a load in EX
    issue(LOAD, 1'b1);
    tick();
    tick();
    check("prerst_valid", valid_e, 1);
    check("prerst_res_m", result_src_m, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid_e", valid_e, 0);
    check("arst_rw_e", reg_write_e, 0);
    check("arst_res_e", result_src_e, 0);
    check("arst_rw_m", reg_write_m, 0);
    check("arst_res_m", result_src_m, 0);
    check("arst_rw_w", reg_write_w, 0);
    check("arst_res_w", result_src_w, 0);
    check("arst_cnt", illegal_cnt, 0);
    check("arst_illegal_o", illegal_o, 0);
    check("arst_pcsrc", pc_src_e, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", valid_e, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
